// File: rtl/icache_refill_unit_pkg.sv
// Shared definitions for the instruction-cache line-fill path.
// ICache and icache_refill_unit both size their lines from BLOCK_WIDTH_DEFAULT,
// so a line-size change is made here once and both sides stay in agreement.
package icache_refill_unit_pkg;

   // log2 of bytes per cache line (4 -> 16-byte, 128-bit lines)
   localparam int BLOCK_WIDTH_DEFAULT = 4;

   // Refill engine state encoding
   typedef enum logic [1:0] {
      IDLE  = 2'd0,   // waiting for a miss
      REQ   = 2'd1,   // requesting the shared RAM port
      FETCH = 2'd2,   // issuing byte reads and collecting returned bytes
      DONE  = 2'd3    // presenting the assembled line for one cycle
   } refillState_t;

endpackage

// File: rtl/icache_refill_unit.sv
// icache_refill_unit
// Line-fill engine for the instruction cache. On a miss it latches the line
// address, requests the shared byte-wide RAM port, reads BLOCK_SIZE consecutive
// bytes, assembles them little-endian into one line and presents that line to
// ICache for exactly one cycle.
//
// Ports
//   clkIn         system clock, single domain
//   resetIn       synchronous active-low reset
//   missValid     ICache miss with a valid request (accepted only in IDLE)
//   missAddr      faulting instruction address; low BLOCK_WIDTH bits ignored
//   flushIn       abandon any refill in progress
//   ramReq        request for the shared RAM port
//   ramGrant      arbiter grant
//   ramReadEn     byte read strobe
//   ramAddr       byte address of the current read
//   ramDataIn     read data, valid one cycle after ramReadEn
//   memDataValid  one-cycle pulse: line complete
//   memAddr       line address [31:BLOCK_WIDTH] of the completed line
//   memDataOut    assembled line, byte i at bits [8i+7:8i]
//   busy          engine is not IDLE
//
// RAM port handshake: ramReq is raised on entry to REQ and held through FETCH.
// The arbiter answers with ramGrant, which it keeps high for as long as ramReq
// stays high; the grant is only sampled in REQ, and the first read strobe goes
// out the cycle after the grant is seen. ramReq drops when the line is
// complete (DONE) or on a flush.
module icache_refill_unit
   import icache_refill_unit_pkg::*;
#(
   parameter int BLOCK_WIDTH = BLOCK_WIDTH_DEFAULT
) (
   input  logic                          clkIn,
   input  logic                          resetIn,
   input  logic                          missValid,
   input  logic [31:0]                   missAddr,
   input  logic                          flushIn,
   output logic                          ramReq,
   input  logic                          ramGrant,
   output logic                          ramReadEn,
   output logic [31:0]                   ramAddr,
   input  logic [7:0]                    ramDataIn,
   output logic                          memDataValid,
   output logic [31-BLOCK_WIDTH:0]       memAddr,
   output logic [(2**BLOCK_WIDTH)*8-1:0] memDataOut,
   output logic                          busy
);

   // Derived from BLOCK_WIDTH so the two can never disagree
   localparam int BLOCK_SIZE = 2**BLOCK_WIDTH;

   // Counters are one bit wider than a byte offset so "all bytes issued" is representable
   localparam logic [BLOCK_WIDTH:0] CNT_ONE  = (BLOCK_WIDTH+1)'(1);
   localparam logic [BLOCK_WIDTH:0] CNT_FULL = (BLOCK_WIDTH+1)'(BLOCK_SIZE);
   localparam logic [BLOCK_WIDTH:0] CNT_LAST = (BLOCK_WIDTH+1)'(BLOCK_SIZE-1);

   refillState_t                state;
   logic [31-BLOCK_WIDTH:0]     lineAddr;
   logic [BLOCK_WIDTH:0]        issueCnt;
   logic [BLOCK_WIDTH:0]        rxCnt;
   logic                        rdPend;
   logic                        doneReg;

   // The byte offset of the miss address is irrelevant: whole lines are fetched
   logic unusedMissOffset;
   assign unusedMissOffset = &{1'b0, missAddr[BLOCK_WIDTH-1:0]};

   assign busy = (state != IDLE);

   // A flush arriving in DONE still cancels the line, so the registered pulse is
   // gated by the live flush input.
   assign memDataValid = doneReg & ~flushIn;

   always_ff @(posedge clkIn) begin
      if (!resetIn) begin
         state      <= IDLE;
         lineAddr   <= '0;
         issueCnt   <= '0;
         rxCnt      <= '0;
         rdPend     <= 1'b0;
         doneReg    <= 1'b0;
         ramReq     <= 1'b0;
         ramReadEn  <= 1'b0;
         ramAddr    <= '0;
         memAddr    <= '0;
         memDataOut <= '0;
      end else begin
         // Read data lands one cycle after its strobe
         rdPend  <= ramReadEn;
         doneReg <= 1'b0;

         case (state)
            IDLE: begin
               // A simultaneous flush wins over a new miss
               if (missValid && !flushIn) begin
                  lineAddr <= missAddr[31:BLOCK_WIDTH];
                  issueCnt <= '0;
                  rxCnt    <= '0;
                  ramReq   <= 1'b1;
                  state    <= REQ;
               end
            end

            REQ: begin
               if (flushIn) begin
                  ramReq <= 1'b0;
                  state  <= IDLE;
               end else if (ramGrant) begin
                  // Issue byte 0 on the grant edge so reads start in the next cycle
                  ramReadEn <= 1'b1;
                  ramAddr   <= {lineAddr, {BLOCK_WIDTH{1'b0}}};
                  issueCnt  <= CNT_ONE;
                  state     <= FETCH;
               end
            end

            FETCH: begin
               if (flushIn) begin
                  // Drop the port and discard any byte still in flight
                  ramReq    <= 1'b0;
                  ramReadEn <= 1'b0;
                  rdPend    <= 1'b0;
                  state     <= IDLE;
               end else begin
                  if (issueCnt < CNT_FULL) begin
                     ramReadEn <= 1'b1;
                     ramAddr   <= {lineAddr, issueCnt[BLOCK_WIDTH-1:0]};
                     issueCnt  <= issueCnt + CNT_ONE;
                  end else begin
                     ramReadEn <= 1'b0;
                  end

                  if (rdPend) begin
                     memDataOut[8*rxCnt[BLOCK_WIDTH-1:0] +: 8] <= ramDataIn;
                     rxCnt <= rxCnt + CNT_ONE;
                     if (rxCnt == CNT_LAST) begin
                        ramReq  <= 1'b0;
                        doneReg <= 1'b1;
                        memAddr <= lineAddr;
                        state   <= DONE;
                     end
                  end
               end
            end

            DONE: begin
               // One-cycle presentation; a flush here only suppresses the pulse
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_icache_refill_unit.sv
// Bench for icache_refill_unit (BLOCK_WIDTH = 4, 16-byte lines).
// The RAM content is a function of the byte address and a per-test seed; the
// expected line and read-address sequence are built from that function, and
// timing is checked against the grant cycle G (reads in G+1..G+16, pulse in G+18).
module tb_icache_refill_unit;

   // ---------------- clock / reset / DUT ----------------
   logic          clkIn     = 1'b0;
   logic          resetIn   = 1'b0;
   logic          missValid = 1'b0;
   logic [31:0]   missAddr  = '0;
   logic          flushIn   = 1'b0;
   logic          ramGrant  = 1'b0;
   logic [7:0]    ramDataIn = 8'h00;
   logic          ramReq;
   logic          ramReadEn;
   logic [31:0]   ramAddr;
   logic          memDataValid;
   logic [27:0]   memAddr;
   logic [127:0]  memDataOut;
   logic          busy;

   int checks   = 0;
   int failures = 0;

   logic [7:0]    ramSeed = 8'h00;

   always #5 clkIn = ~clkIn;

   icache_refill_unit dut (
      .clkIn        (clkIn),
      .resetIn      (resetIn),
      .missValid    (missValid),
      .missAddr     (missAddr),
      .flushIn      (flushIn),
      .ramReq       (ramReq),
      .ramGrant     (ramGrant),
      .ramReadEn    (ramReadEn),
      .ramAddr      (ramAddr),
      .ramDataIn    (ramDataIn),
      .memDataValid (memDataValid),
      .memAddr      (memAddr),
      .memDataOut   (memDataOut),
      .busy         (busy)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: run not finished at time %0t, limit 200000", $time);
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model ----------------
   // Byte stored at a RAM address; with seed 0 byte k of a line is 0x10+k
   function automatic logic [7:0] ram_byte(input logic [31:0] a);
      return (8'h10 + {4'h0, a[3:0]}) ^ 8'(ramSeed * (a[15:0] + 16'd1));
   endfunction

   function automatic logic [127:0] model_line(input logic [31:0] a);
      logic [127:0] l;
      for (int k = 0; k < 16; k++) l[8*k +: 8] = ram_byte({a[31:4], 4'(k)});
      return l;
   endfunction

   // RAM responder: data appears the cycle after the strobe
   always @(posedge clkIn) begin
      if (ramReadEn === 1'b1) ramDataIn <= ram_byte(ramAddr);
      else                    ramDataIn <= 8'hEE;
   end

   // ---------------- scoreboard storage ----------------
   logic [31:0]   exp_q[$];
   logic [31:0]   obsRdAddr[$];
   int            obsRdCyc[$];
   int            obsPulseCyc[$];
   logic [27:0]   obsPulseAddr[$];
   logic [127:0]  obsPulseData[$];
   logic          obsPulseReq[$];
   int            obsGrantViol;
   logic          obsReqRose;
   logic          obsBusyEnd;
   logic          obsReqEnd;
   logic          obsRenEnd;
   logic [127:0]  obsDataEnd;

   task automatic fill_exp(input logic [31:0] a);
      exp_q.delete();
      for (int k = 0; k < 16; k++) exp_q.push_back({a[31:4], 4'(k)});
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clkIn);
      #1;
   endtask

   // Present a miss in the current cycle, withhold grant grantDelay cycles,
   // then record activity for cycles G+1..G+stopAt. flushAt raises flushIn
   // during cycle G+flushAt. noise toggles missValid/missAddr while busy.
   task automatic drive_refill(input logic [31:0] addr, input int grantDelay,
                               input int flushAt, input bit noise, input int stopAt);
      obsRdAddr.delete();
      obsRdCyc.delete();
      obsPulseCyc.delete();
      obsPulseAddr.delete();
      obsPulseData.delete();
      obsPulseReq.delete();
      obsGrantViol = 0;
      flushIn   = 1'b0;
      ramGrant  = 1'b0;
      missValid = 1'b1;
      missAddr  = addr;
      tick();
      missValid = 1'b0;
      #1;
      obsReqRose = (ramReq === 1'b1) && (ramReadEn === 1'b0);
      for (int d = 0; d < grantDelay; d++) begin
         if (noise) begin
            missValid = 1'($urandom_range(0, 1));
            missAddr  = $urandom;
         end
         tick();
         if (ramReq !== 1'b1 || ramReadEn !== 1'b0 || busy !== 1'b1) obsGrantViol++;
      end
      ramGrant = 1'b1;
      tick();
      for (int rel = 1; rel <= stopAt; rel++) begin
         flushIn = (rel == flushAt);
         if (noise) begin
            missValid = (rel <= 18) ? 1'($urandom_range(0, 1)) : 1'b0;
            missAddr  = $urandom;
         end
         #1;
         if (ramReadEn === 1'b1) begin
            obsRdAddr.push_back(ramAddr);
            obsRdCyc.push_back(rel);
         end
         if (memDataValid === 1'b1) begin
            obsPulseCyc.push_back(rel);
            obsPulseAddr.push_back(memAddr);
            obsPulseData.push_back(memDataOut);
            obsPulseReq.push_back(ramReq);
         end
         obsBusyEnd = busy;
         obsReqEnd  = ramReq;
         obsRenEnd  = ramReadEn;
         obsDataEnd = memDataOut;
         ramGrant   = ramReq;
         if (rel < stopAt) tick();
      end
      flushIn   = 1'b0;
      missValid = 1'b0;
      ramGrant  = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int pulses;
      int busyCycles;
      resetIn = 1'b0;
      tick();
      tick();
      checks++; if ({ramReq, ramReadEn, memDataValid, busy} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {ramReq, ramReadEn, memDataValid, busy}); end
      checks++; if (ramAddr !== 32'h0) begin failures++; $display("FAIL reset_ramAddr got=%h exp=0", ramAddr); end
      checks++; if (memAddr !== 28'h0 || memDataOut !== 128'h0) begin failures++; $display("FAIL reset_mem got=%h/%h exp=0/0", memAddr, memDataOut); end
      resetIn = 1'b1;
      tick();
      checks++; if (busy !== 1'b0 || ramReq !== 1'b0) begin failures++; $display("FAIL reset_release got=%b%b exp=00", busy, ramReq); end

      // Reset in the middle of FETCH
      ramSeed   = 8'h21;
      missValid = 1'b1;
      missAddr  = 32'h0000_4440;
      tick();
      missValid = 1'b0;
      ramGrant  = 1'b1;
      tick();
      repeat (4) tick();
      checks++; if (ramReadEn !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL reset_prefetch got=%b%b exp=11", ramReadEn, busy); end
      resetIn  = 1'b0;
      ramGrant = 1'b0;
      tick();
      tick();
      checks++; if ({ramReq, ramReadEn, memDataValid, busy} !== 4'b0000) begin failures++; $display("FAIL reset_mid_flags got=%b exp=0000", {ramReq, ramReadEn, memDataValid, busy}); end
      checks++; if (ramAddr !== 32'h0 || memAddr !== 28'h0 || memDataOut !== 128'h0) begin failures++; $display("FAIL reset_mid_regs got=%h/%h/%h exp=0", ramAddr, memAddr, memDataOut); end
      resetIn    = 1'b1;
      pulses     = 0;
      busyCycles = 0;
      for (int c = 0; c < 25; c++) begin
         ramGrant = ramReq;
         tick();
         if (memDataValid === 1'b1) pulses++;
         if (busy !== 1'b0) busyCycles++;
      end
      ramGrant = 1'b0;
      checks++; if (pulses != 0 || busyCycles != 0) begin failures++; $display("FAIL reset_mid_quiet got pulses=%0d busy=%0d exp=0/0", pulses, busyCycles); end
   endtask

   task automatic test_basic();
      logic [127:0] expLine;
      logic [31:0]  e;
      expLine = 128'h1F1E1D1C1B1A19181716151413121110;
      ramSeed = 8'h00;
      fill_exp(32'h0000_1234);
      drive_refill(32'h0000_1234, 0, 0, 1'b0, 19);
      checks++; if (obsReqRose !== 1'b1) begin failures++; $display("FAIL basic_req_rise got=%b exp=1", obsReqRose); end
      checks++; if (obsRdAddr.size() != 16) begin failures++; $display("FAIL basic_read_count got=%0d exp=16", obsRdAddr.size()); end
      for (int k = 0; k < obsRdAddr.size(); k++) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
         checks++; if (obsRdAddr[k] !== e || obsRdCyc[k] != k + 1) begin failures++; $display("FAIL basic_read[%0d] got=%h@%0d exp=%h@%0d", k, obsRdAddr[k], obsRdCyc[k], e, k + 1); end
      end
      checks++;
      if (obsPulseCyc.size() != 1) begin
         failures++; $display("FAIL basic_pulse_count got=%0d exp=1", obsPulseCyc.size());
      end else begin
         checks++; if (obsPulseCyc[0] != 18) begin failures++; $display("FAIL basic_pulse_cycle got=G+%0d exp=G+18", obsPulseCyc[0]); end
         checks++; if (obsPulseAddr[0] !== 28'h0000123) begin failures++; $display("FAIL basic_memAddr got=%h exp=0000123", obsPulseAddr[0]); end
         checks++; if (obsPulseData[0] !== expLine) begin failures++; $display("FAIL basic_line got=%h exp=%h", obsPulseData[0], expLine); end
         checks++; if (obsPulseReq[0] !== 1'b0) begin failures++; $display("FAIL basic_req_in_done got=%b exp=0", obsPulseReq[0]); end
      end
      checks++; if (obsBusyEnd !== 1'b0 || obsDataEnd !== expLine) begin failures++; $display("FAIL basic_after got busy=%b line=%h exp busy=0 line=%h", obsBusyEnd, obsDataEnd, expLine); end
   endtask

   task automatic test_grant_delay();
      logic [127:0] expLine;
      logic [31:0]  e;
      expLine = 128'h1F1E1D1C1B1A19181716151413121110;
      ramSeed = 8'h00;
      fill_exp(32'h0000_1234);
      drive_refill(32'h0000_1234, 5, 0, 1'b0, 19);
      checks++; if (obsReqRose !== 1'b1 || obsGrantViol != 0) begin failures++; $display("FAIL gdelay_hold got rose=%b viol=%0d exp rose=1 viol=0", obsReqRose, obsGrantViol); end
      checks++; if (obsRdAddr.size() != 16) begin failures++; $display("FAIL gdelay_read_count got=%0d exp=16", obsRdAddr.size()); end
      for (int k = 0; k < obsRdAddr.size(); k++) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
         checks++; if (obsRdAddr[k] !== e || obsRdCyc[k] != k + 1) begin failures++; $display("FAIL gdelay_read[%0d] got=%h@%0d exp=%h@%0d", k, obsRdAddr[k], obsRdCyc[k], e, k + 1); end
      end
      checks++;
      if (obsPulseCyc.size() != 1) begin
         failures++; $display("FAIL gdelay_pulse_count got=%0d exp=1", obsPulseCyc.size());
      end else begin
         checks++; if (obsPulseCyc[0] != 18 || obsPulseData[0] !== expLine) begin failures++; $display("FAIL gdelay_pulse got=G+%0d %h exp=G+18 %h", obsPulseCyc[0], obsPulseData[0], expLine); end
      end
   endtask

   task automatic test_flush();
      logic [127:0] expLine;
      logic [31:0]  e;
      // Flush during the 8th FETCH cycle
      ramSeed = 8'h3C;
      drive_refill(32'h0000_3000, 0, 8, 1'b0, 9);
      checks++; if (obsPulseCyc.size() != 0) begin failures++; $display("FAIL flush_fetch_pulse got=%0d exp=0", obsPulseCyc.size()); end
      checks++; if (obsRdAddr.size() != 8) begin failures++; $display("FAIL flush_fetch_reads got=%0d exp=8", obsRdAddr.size()); end
      checks++; if ({obsReqEnd, obsRenEnd, obsBusyEnd} !== 3'b000) begin failures++; $display("FAIL flush_fetch_drop got=%b exp=000", {obsReqEnd, obsRenEnd, obsBusyEnd}); end
      // Miss the very next cycle refills correctly
      expLine = model_line(32'h0000_2000);
      fill_exp(32'h0000_2000);
      drive_refill(32'h0000_2000, 0, 0, 1'b0, 19);
      checks++; if (obsRdAddr.size() != 16) begin failures++; $display("FAIL flush_refill_reads got=%0d exp=16", obsRdAddr.size()); end
      for (int k = 0; k < obsRdAddr.size(); k++) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
         checks++; if (obsRdAddr[k] !== e) begin failures++; $display("FAIL flush_refill_read[%0d] got=%h exp=%h", k, obsRdAddr[k], e); end
      end
      checks++;
      if (obsPulseCyc.size() != 1) begin
         failures++; $display("FAIL flush_refill_pulse_count got=%0d exp=1", obsPulseCyc.size());
      end else begin
         checks++; if (obsPulseAddr[0] !== 28'h0000200 || obsPulseData[0] !== expLine) begin failures++; $display("FAIL flush_refill_line got=%h %h exp=0000200 %h", obsPulseAddr[0], obsPulseData[0], expLine); end
      end
      // Flush in DONE suppresses the pulse
      drive_refill(32'h0000_5670, 1, 18, 1'b0, 19);
      checks++; if (obsPulseCyc.size() != 0 || obsBusyEnd !== 1'b0) begin failures++; $display("FAIL flush_done got pulses=%0d busy=%b exp=0/0", obsPulseCyc.size(), obsBusyEnd); end
      // Flush in REQ
      missValid = 1'b1;
      missAddr  = 32'h0000_7000;
      tick();
      missValid = 1'b0;
      flushIn   = 1'b1;
      tick();
      flushIn   = 1'b0;
      checks++; if (ramReq !== 1'b0 || busy !== 1'b0 || ramReadEn !== 1'b0) begin failures++; $display("FAIL flush_req got=%b%b%b exp=000", ramReq, busy, ramReadEn); end
      // Flush and miss together in IDLE: flush wins
      missValid = 1'b1;
      missAddr  = 32'h0000_7100;
      flushIn   = 1'b1;
      tick();
      missValid = 1'b0;
      flushIn   = 1'b0;
      checks++; if (ramReq !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL flush_idle_miss got=%b%b exp=00", ramReq, busy); end
      tick();
   endtask

   task automatic test_ignore_miss();
      logic [127:0] expLine;
      logic [31:0]  e;
      ramSeed = 8'hA7;
      expLine = model_line(32'h0000_9AB4);
      fill_exp(32'h0000_9AB4);
      drive_refill(32'h0000_9AB4, 2, 0, 1'b1, 19);
      checks++; if (obsRdAddr.size() != 16) begin failures++; $display("FAIL ignore_read_count got=%0d exp=16", obsRdAddr.size()); end
      for (int k = 0; k < obsRdAddr.size(); k++) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
         checks++; if (obsRdAddr[k] !== e) begin failures++; $display("FAIL ignore_read[%0d] got=%h exp=%h", k, obsRdAddr[k], e); end
      end
      checks++;
      if (obsPulseCyc.size() != 1) begin
         failures++; $display("FAIL ignore_pulse_count got=%0d exp=1", obsPulseCyc.size());
      end else begin
         checks++; if (obsPulseAddr[0] !== 28'h00009AB || obsPulseData[0] !== expLine) begin failures++; $display("FAIL ignore_line got=%h %h exp=00009AB %h", obsPulseAddr[0], obsPulseData[0], expLine); end
      end
      checks++; if (obsBusyEnd !== 1'b0) begin failures++; $display("FAIL ignore_busy_end got=%b exp=0", obsBusyEnd); end
   endtask

   task automatic test_back_to_back();
      int           firstCount;
      logic [27:0]  firstAddr;
      logic [127:0] firstData;
      ramSeed = 8'h55;
      drive_refill(32'h0000_0100, 0, 0, 1'b0, 19);
      firstCount = obsPulseCyc.size();
      firstAddr  = (firstCount > 0) ? obsPulseAddr[0] : 28'hFFFFFFF;
      firstData  = (firstCount > 0) ? obsPulseData[0] : 128'h0;
      drive_refill(32'h0000_0110, 0, 0, 1'b0, 19);
      checks++; if (firstCount != 1 || firstAddr !== 28'h0000010) begin failures++; $display("FAIL b2b_first got count=%0d addr=%h exp=1 0000010", firstCount, firstAddr); end
      checks++; if (firstData !== model_line(32'h0000_0100)) begin failures++; $display("FAIL b2b_first_line got=%h exp=%h", firstData, model_line(32'h0000_0100)); end
      checks++; if (obsReqRose !== 1'b1) begin failures++; $display("FAIL b2b_req_rise got=%b exp=1", obsReqRose); end
      checks++;
      if (obsPulseCyc.size() != 1) begin
         failures++; $display("FAIL b2b_second_count got=%0d exp=1", obsPulseCyc.size());
      end else begin
         checks++; if (obsPulseAddr[0] !== 28'h0000011 || obsPulseData[0] !== model_line(32'h0000_0110)) begin failures++; $display("FAIL b2b_second got=%h %h exp=0000011 %h", obsPulseAddr[0], obsPulseData[0], model_line(32'h0000_0110)); end
      end
   endtask

   task automatic test_random();
      logic [31:0]  a;
      logic [31:0]  e;
      logic [127:0] expLine;
      int           dly;
      bit           noise;
      for (int it = 0; it < 12; it++) begin
         ramSeed = 8'($urandom);
         a       = $urandom;
         dly     = $urandom_range(0, 6);
         noise   = 1'($urandom_range(0, 1));
         expLine = model_line(a);
         fill_exp(a);
         drive_refill(a, dly, 0, noise, 19);
         checks++; if (obsGrantViol != 0 || obsRdAddr.size() != 16) begin failures++; $display("FAIL rand[%0d]_reads got viol=%0d count=%0d exp=0/16", it, obsGrantViol, obsRdAddr.size()); end
         for (int k = 0; k < obsRdAddr.size(); k++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            checks++; if (obsRdAddr[k] !== e || obsRdCyc[k] != k + 1) begin failures++; $display("FAIL rand[%0d]_read[%0d] got=%h@%0d exp=%h@%0d", it, k, obsRdAddr[k], obsRdCyc[k], e, k + 1); end
         end
         checks++;
         if (obsPulseCyc.size() != 1) begin
            failures++; $display("FAIL rand[%0d]_pulse_count got=%0d exp=1", it, obsPulseCyc.size());
         end else begin
            checks++; if (obsPulseCyc[0] != 18 || obsPulseAddr[0] !== a[31:4]) begin failures++; $display("FAIL rand[%0d]_pulse got=G+%0d %h exp=G+18 %h", it, obsPulseCyc[0], obsPulseAddr[0], a[31:4]); end
            checks++; if (obsPulseData[0] !== expLine) begin failures++; $display("FAIL rand[%0d]_line got=%h exp=%h", it, obsPulseData[0], expLine); end
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_basic();
      test_grant_delay();
      test_flush();
      test_ignore_miss();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
